hazard_control: RTL
===================

Name: hazard_control

Overview:
- Pipeline hazard and stall controller for the 5-stage core. The forwarding unit resolves EX-stage operand reads from later stages; this block covers the hazards forwarding cannot resolve.
- Functions:
  - Detects load-use hazards between ID and EX.
  - Flushes on taken branches.
  - Freezes the pipeline while the data-memory handshake is pending.
  - Sequences the halt drain.
- Drives the PC and pipeline-register write-enable/flush controls.

Parameters:
- DRAIN_CYCLES, 3, cycles of bubble injection after a halt leaves ID before halted asserts (1..15).
- MAX_WAIT, 255, consecutive frozen cycles before mem_timeout sets (1..255).

Ports:
- clk  in  1  clock, rising edge.
- rstn  in  1  asynchronous active-low reset.
- id_rs1  in  5  rs1 of instruction in ID.
- id_rs2  in  5  rs2 of instruction in ID.
- id_use_rs1  in  1  ID instruction reads rs1.
- id_use_rs2  in  1  ID instruction reads rs2.
- id_halt  in  1  ID instruction is a halt (ecall).
- ex_rd  in  5  destination register in EX.
- ex_memread  in  1  EX instruction is a load.
- ex_branch_taken  in  1  EX resolved a taken branch/jump.
- dmem_req  in  1  MEM stage has an outstanding data-memory request.
- dmem_ready  in  1  data memory completes the request this cycle.
- pc_write  out  1  PC update enable.
- if_id_write  out  1  IF/ID register load enable.
- if_id_flush  out  1  IF/ID loads a bubble.
- id_ex_write  out  1  ID/EX register load enable.
- id_ex_flush  out  1  ID/EX loads a bubble.
- ex_mem_write  out  1  EX/MEM register load enable.
- mem_wb_flush  out  1  MEM/WB loads a bubble.
- halted  out  1  drain complete; core stopped.
- mem_timeout  out  1  sticky: freeze exceeded MAX_WAIT.
- stall_lu_cnt  out  32  load-use stall cycles (optional feature).
- freeze_cnt  out  32  memory-freeze cycles (optional feature).

Behaviour:
- Signal definitions:
  - freeze = dmem_req & ~dmem_ready.
  - lu = ex_memread & ex_rd!=0 & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).
- Control outputs are combinational from state and inputs and take effect in the same cycle.
  - While rstn is low, all write enables and flushes are 0.
  - halted and mem_timeout reset to 0.
- Default (RUN, no event): all write enables 1, all flushes 0.
- Priority per cycle: freeze > branch > load-use > halt entry.
  - freeze:
    - pc_write, if_id_write, id_ex_write and ex_mem_write are 0; mem_wb_flush is 1.
    - A taken branch is held in EX and is flushed on the first unfrozen cycle.
  - ex_branch_taken:
    - if_id_flush and id_ex_flush are 1; pc_write is 1.
    - lu and id_halt are ignored because the ID instruction is killed.
  - lu: pc_write and if_id_write are 0, id_ex_flush is 1 for exactly one cycle. The next cycle has no lu because EX now holds the bubble.
- FSM states: RUN, DRAIN, HALTED; reset state RUN.
  - RUN -> DRAIN: id_halt & ~freeze & ~ex_branch_taken & ~lu. The halt instruction advances into EX that edge. The drain counter loads DRAIN_CYCLES.
  - DRAIN:
    - pc_write=0, if_id_flush=1, others default.
    - The counter decrements on each unfrozen cycle and holds while frozen.
    - Goes to HALTED when the counter is 1 and the cycle is unfrozen.
  - HALTED:
    - pc_write, if_id_write, id_ex_write and ex_mem_write are 0; flushes are 0.
    - halted=1.
    - Leaves only on reset.
- Wait counter (8 bits):
  - Increments each freeze cycle, saturates at MAX_WAIT, and clears on any unfrozen cycle.
  - mem_timeout sets on the edge where the counter reaches MAX_WAIT and stays set until reset.
  - The freeze continues regardless of mem_timeout.
- Boundary cases:
  - ex_rd=0 never causes a stall.
  - dmem_ready with dmem_req=0 is ignored.
  - Reset asserted mid-drain or mid-freeze returns immediately to RUN with all counters at 0.

Optional Feature:
- Macro HAZARD_STATS_EN.
- Defined:
  - stall_lu_cnt increments on each cycle where lu is acted on (not overridden by freeze or branch).
  - freeze_cnt increments on each freeze cycle.
  - Both are 32-bit wrapping counters, reset to 0, and not incremented in HALTED.
- Undefined: both ports are present and tied to 0, and no counter registers are built.

Test Plan:
- Load-use: ex_memread=1, ex_rd=5, id_rs1=5, id_use_rs1=1 for one cycle -> pc_write=0, if_id_write=0, id_ex_flush=1 that cycle only; with the feature, stall_lu_cnt=1.
- Zero register: same as above with ex_rd=0, id_rs1=0 -> no stall; all write enables 1.
- Branch over load-use: ex_branch_taken=1 together with a lu condition -> if_id_flush=1, id_ex_flush=1, pc_write=1; no stall.
- Freeze with branch: dmem_req=1, dmem_ready=0 for 4 cycles with ex_branch_taken=1 -> 4 cycles of all enables 0 and mem_wb_flush=1; flush occurs on the 5th cycle; freeze_cnt=4.
- Halt drain: id_halt=1 in RUN, with a 2-cycle freeze inserted mid-drain -> halted=1 exactly DRAIN_CYCLES+2 cycles after the entry edge; pc_write=0 throughout.
- Timeout and reset: MAX_WAIT=3, freeze held for 5 cycles -> mem_timeout=1 from the 3rd edge and stays set; asserting rstn low -> mem_timeout=0, state RUN.

Source files
------------

// File: rtl/hazard_control.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : hazard_control                                            |
// | Purpose  : Stall, flush and freeze controller for the 5-stage core.  |
// |            Handles load-use hazards, taken-branch flushes, data-     |
// |            memory freezes and the halt drain sequence.               |
// | Options  : `define HAZARD_STATS_EN builds the load-use stall and     |
// |            memory-freeze cycle counters; otherwise both read 0.      |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module hazard_control #(
  parameter int DRAIN_CYCLES = 3,   // 1..15 bubble cycles before halted
  parameter int MAX_WAIT     = 255  // 1..255 frozen cycles before timeout
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_use_rs1,
  input  logic        id_use_rs2,
  input  logic        id_halt,
  input  logic [4:0]  ex_rd,
  input  logic        ex_memread,
  input  logic        ex_branch_taken,
  input  logic        dmem_req,
  input  logic        dmem_ready,
  output logic        pc_write,
  output logic        if_id_write,
  output logic        if_id_flush,
  output logic        id_ex_write,
  output logic        id_ex_flush,
  output logic        ex_mem_write,
  output logic        mem_wb_flush,
  output logic        halted,
  output logic        mem_timeout,
  output logic [31:0] stall_lu_cnt,
  output logic [31:0] freeze_cnt
);

  localparam logic [3:0] C_DRAIN_LOAD = 4'(DRAIN_CYCLES);
  localparam logic [7:0] C_MAX_WAIT   = 8'(MAX_WAIT);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  drain_q, drain_d;
  logic [7:0]  wait_q,  wait_d;
  logic        timeout_q, timeout_d;
  logic        halted_q, halted_d;

  logic        w_freeze;
  logic        w_lu;
  logic        w_branch;
  logic        w_halt_go;
  logic        w_lu_act;
  logic        w_freeze_act;

  // Hazard conditions. A request only freezes the pipe while it is
  // outstanding and not completing; a bare dmem_ready is meaningless.
  assign w_freeze = dmem_req & ~dmem_ready;
  assign w_branch = ex_branch_taken;
  assign w_lu     = ex_memread & (ex_rd != 5'd0) &
                    ((id_use_rs1 & (id_rs1 == ex_rd)) |
                     (id_use_rs2 & (id_rs2 == ex_rd)));

  // Halt only enters the drain when nothing of higher priority is acting
  // on the ID instruction this cycle; otherwise it is retried or killed.
  assign w_halt_go = (state_q == ST_RUN) & id_halt & ~w_freeze &
                     ~w_branch & ~w_lu;

  // Events that the statistics counters record.
  assign w_lu_act     = (state_q == ST_RUN) & w_lu & ~w_freeze & ~w_branch;
  assign w_freeze_act = w_freeze & (state_q != ST_HALTED);

  // Pipeline control outputs: combinational from state and inputs,
  // forced inactive while reset is held.
  always_comb begin
    pc_write     = 1'b0;
    if_id_write  = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_write  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_write = 1'b0;
    mem_wb_flush = 1'b0;
    if (rstn) begin
      unique case (state_q)
        ST_RUN: begin
          pc_write     = 1'b1;
          if_id_write  = 1'b1;
          id_ex_write  = 1'b1;
          ex_mem_write = 1'b1;
          if (w_freeze) begin
            // Hold every stage; MEM/WB receives a bubble so the stalled
            // MEM instruction is not retired twice.
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_write  = 1'b0;
            ex_mem_write = 1'b0;
            mem_wb_flush = 1'b1;
          end else if (w_branch) begin
            // Kill the two younger instructions; PC takes the target.
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
          end else if (w_lu) begin
            // Hold IF and ID one cycle, send a bubble into EX.
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_flush  = 1'b1;
          end
        end
        ST_DRAIN: begin
          if (w_freeze) begin
            mem_wb_flush = 1'b1;
          end else begin
            // Stop fetching and feed bubbles behind the halt.
            if_id_write  = 1'b1;
            if_id_flush  = 1'b1;
            id_ex_write  = 1'b1;
            ex_mem_write = 1'b1;
          end
        end
        ST_HALTED: begin
          // Everything stays frozen until reset.
        end
        default: begin
        end
      endcase
    end
  end

  // Next-state logic for the drain FSM.
  always_comb begin
    state_d  = state_q;
    drain_d  = drain_q;
    halted_d = halted_q;
    unique case (state_q)
      ST_RUN: begin
        if (w_halt_go) begin
          state_d = ST_DRAIN;
          drain_d = C_DRAIN_LOAD;
        end
      end
      ST_DRAIN: begin
        if (!w_freeze) begin
          if (drain_q <= 4'd1) begin
            state_d  = ST_HALTED;
            drain_d  = 4'd0;
            halted_d = 1'b1;
          end else begin
            drain_d = drain_q - 4'd1;
          end
        end
      end
      ST_HALTED: begin
        halted_d = 1'b1;
      end
      default: begin
        state_d = ST_RUN;
        drain_d = 4'd0;
      end
    endcase
  end

  // Freeze wait counter: saturating, cleared by any unfrozen cycle.
  // The timeout flag latches once the counter hits the limit.
  always_comb begin
    wait_d    = 8'd0;
    timeout_d = timeout_q;
    if (w_freeze) begin
      wait_d = (wait_q >= C_MAX_WAIT) ? wait_q : wait_q + 8'd1;
      if (wait_d == C_MAX_WAIT) begin
        timeout_d = 1'b1;
      end
    end
  end

  // FSM, drain counter and registered status outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= ST_RUN;
      drain_q   <= 4'd0;
      halted_q  <= 1'b0;
      wait_q    <= 8'd0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      drain_q   <= drain_d;
      halted_q  <= halted_d;
      wait_q    <= wait_d;
      timeout_q <= timeout_d;
    end
  end

  assign halted      = halted_q;
  assign mem_timeout = timeout_q;

`ifdef HAZARD_STATS_EN
  logic [31:0] lu_cnt_q, lu_cnt_d;
  logic [31:0] fz_cnt_q, fz_cnt_d;

  // Statistics increments; both counters wrap naturally at 2^32.
  always_comb begin
    lu_cnt_d = lu_cnt_q;
    fz_cnt_d = fz_cnt_q;
    if (w_lu_act) begin
      lu_cnt_d = lu_cnt_q + 32'd1;
    end
    if (w_freeze_act) begin
      fz_cnt_d = fz_cnt_q + 32'd1;
    end
  end

  // Statistics registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      lu_cnt_q <= 32'd0;
      fz_cnt_q <= 32'd0;
    end else begin
      lu_cnt_q <= lu_cnt_d;
      fz_cnt_q <= fz_cnt_d;
    end
  end

  assign stall_lu_cnt = lu_cnt_q;
  assign freeze_cnt   = fz_cnt_q;
`else
  // Event terms exist for the counters only; keep them referenced.
  logic w_stats_unused;
  assign w_stats_unused = w_lu_act ^ w_freeze_act;
  assign stall_lu_cnt   = {31'd0, w_stats_unused & 1'b0};
  assign freeze_cnt     = 32'd0;
`endif

endmodule
`default_nettype wire
